// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage program counter.
// Defines the 3-bit op encoding, the stack sizing helper and defaults.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } pc_op_t;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OPC_NEXT   = 3'd0;
  localparam logic [OP_W-1:0] OPC_JUMP   = 3'd1;
  localparam logic [OP_W-1:0] OPC_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OPC_CALL   = 3'd3;
  localparam logic [OP_W-1:0] OPC_RET    = 3'd4;
  localparam logic [OP_W-1:0] OPC_HOLD   = 3'd5;

  localparam int unsigned DEF_PC_W     = 6;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_RESET_PC = 0;

  // Index width for an array of n entries; never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO return-address stack with async active-low reset.
// Ports: push_i/pop_i/data_i in; top_o/empty_o/full_o out, from count.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = idx_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);

  // Guard here too so the stack stays consistent even if misused.
  assign do_push = push_i && !full_o && !pop_i;
  assign do_pop  = pop_i && !empty_o && !push_i;

  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));

  // Empty stack exposes zero rather than a stale slot.
  assign top_o = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC with jump, branch, hold and call/return stack.
// Ports: clk, reset(n), en, op, target, offset, err_clr in; pc, flags out.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned STACK_DEPTH = DEF_DEPTH,
  parameter int unsigned RESET_PC    = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] offset,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] top;
  logic            ovf_q;
  logic            ovf_d;
  logic            unf_q;
  logic            unf_d;
  logic            push;
  logic            pop;
  logic            ovf_set;
  logic            unf_set;
  logic            empty;
  logic            full;

  // Modular add covers signed offsets and both wrap directions.
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_q + offset;

  pc_ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (top),
    .empty_o (empty),
    .full_o  (full)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      case (op)
        OPC_NEXT:   pc_d = pc_inc;
        OPC_JUMP:   pc_d = target;
        OPC_BRANCH: pc_d = pc_br;
        OPC_CALL: begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        OPC_RET: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // A new error in the clear cycle wins over the clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RST_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc          = pc_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
